// File: rtl/ledtoggle_onchip_mem_arbiter_pkg.sv
// Shared types for the two-master on-chip memory arbiter.
// Grant/owner encoding and burst counter width.
package ledtoggle_arb_pkg;

  localparam int BURST_W = 4;
  localparam logic [BURST_W-1:0] BURST_SAT = '1;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } owner_e;

  typedef struct packed {
    logic   vld;
    owner_e own;
  } rd_tag_t;

endpackage

// File: rtl/ledtoggle_onchip_mem_arbiter_if.sv
// Master A/B bus and single-port RAM signals of the arbiter.
// slave = arbiter side, master = requesters plus RAM model.
interface ledtoggle_onchip_mem_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] a_address;
  logic [BE_W-1:0]   a_byteenable;
  logic              a_read;
  logic              a_write;
  logic [DATA_W-1:0] a_writedata;
  logic              a_waitrequest;
  logic [DATA_W-1:0] a_readdata;
  logic              a_readdatavalid;

  logic [ADDR_W-1:0] b_address;
  logic [BE_W-1:0]   b_byteenable;
  logic              b_read;
  logic              b_write;
  logic [DATA_W-1:0] b_writedata;
  logic              b_waitrequest;
  logic [DATA_W-1:0] b_readdata;
  logic              b_readdatavalid;

  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  modport slave (
    input  a_address, a_byteenable, a_read,
    input  a_write, a_writedata,
    output a_waitrequest, a_readdata,
    output a_readdatavalid,
    input  b_address, b_byteenable, b_read,
    input  b_write, b_writedata,
    output b_waitrequest, b_readdata,
    output b_readdatavalid,
    output mem_address, mem_byteenable,
    output mem_chipselect, mem_write,
    output mem_writedata, mem_clken,
    input  mem_readdata
  );

  modport master (
    output a_address, a_byteenable, a_read,
    output a_write, a_writedata,
    input  a_waitrequest, a_readdata,
    input  a_readdatavalid,
    output b_address, b_byteenable, b_read,
    output b_write, b_writedata,
    input  b_waitrequest, b_readdata,
    input  b_readdatavalid,
    input  mem_address, mem_byteenable,
    input  mem_chipselect, mem_write,
    input  mem_writedata, mem_clken,
    output mem_readdata
  );

endinterface

// File: rtl/ledtoggle_onchip_mem_arbiter_rr_pick.sv
// Next-grant selection for the two-master arbiter.
// LEDTOGGLE_ARB_FIXED_PRI_EN selects fixed A-over-B priority.
module ledtoggle_arb_rr_pick
  import ledtoggle_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic               req_a,
  input  logic               req_b,
  input  owner_e             last_grant,
  input  logic [BURST_W-1:0] burst_cnt,
  output logic               gnt_vld,
  output owner_e             gnt
);

  logic   keep;
  owner_e rr_gnt;

  // A zero count means no grant since reset, so the holder yields.
  assign keep = (burst_cnt != '0)
             && (burst_cnt < BURST_W'(MAX_BURST));

  always_comb begin
    rr_gnt = GNT_A;
    unique case (1'b1)
      req_a && !req_b:         rr_gnt = GNT_A;
      !req_a && req_b:         rr_gnt = GNT_B;
      req_a && req_b && keep:  rr_gnt = last_grant;
      req_a && req_b && !keep: rr_gnt = owner_e'(~last_grant);
      default:                 rr_gnt = GNT_A;
    endcase
  end

  assign gnt_vld = req_a | req_b;

`ifdef LEDTOGGLE_ARB_FIXED_PRI_EN
  logic unused_rr;
  assign unused_rr = rr_gnt;
  assign gnt = req_a ? GNT_A : GNT_B;
`else
  assign gnt = rr_gnt;
`endif

endmodule

// File: rtl/ledtoggle_onchip_mem_arbiter.sv
// Two-master arbiter in front of a single-port on-chip RAM.
// LEDTOGGLE_ARB_FIXED_PRI_EN: fixed priority instead of round-robin.
module ledtoggle_onchip_mem_arbiter
  import ledtoggle_arb_pkg::*;
#(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input logic clk,
  input logic reset_n,
  input logic reset_req,
  ledtoggle_onchip_mem_arbiter_if.slave bus
);

  logic               req_a;
  logic               req_b;
  logic               pick_vld;
  owner_e             pick;
  owner_e             last_grant;
  logic [BURST_W-1:0] burst_cnt;
  rd_tag_t            tag;
  logic               grant_en;
  logic               gnt_a;
  logic               gnt_b;
  logic               gnt_any;
  logic               gnt_wr;
  logic               rd_issue;
  owner_e             gnt_own;

  assign req_a = bus.a_read | bus.a_write;
  assign req_b = bus.b_read | bus.b_write;

  ledtoggle_arb_rr_pick #(
    .MAX_BURST (MAX_BURST)
  ) u_pick (
    .req_a      (req_a),
    .req_b      (req_b),
    .last_grant (last_grant),
    .burst_cnt  (burst_cnt),
    .gnt_vld    (pick_vld),
    .gnt        (pick)
  );

  // Nothing is accepted while in reset or during a memory reset.
  assign grant_en = reset_n & ~reset_req;
  assign gnt_a    = grant_en & pick_vld & (pick == GNT_A);
  assign gnt_b    = grant_en & pick_vld & (pick == GNT_B);
  assign gnt_any  = gnt_a | gnt_b;
  assign gnt_own  = gnt_b ? GNT_B : GNT_A;
  assign gnt_wr   = gnt_b ? bus.b_write : bus.a_write;
  assign rd_issue = gnt_any & ~gnt_wr;

  assign bus.a_waitrequest = ~gnt_a;
  assign bus.b_waitrequest = ~gnt_b;

  assign bus.mem_address    = gnt_b ? bus.b_address
                                    : bus.a_address;
  assign bus.mem_byteenable = gnt_b ? bus.b_byteenable
                                    : bus.a_byteenable;
  assign bus.mem_writedata  = gnt_b ? bus.b_writedata
                                    : bus.a_writedata;
  assign bus.mem_chipselect = gnt_any;
  assign bus.mem_write      = gnt_any & gnt_wr;
  assign bus.mem_clken      = ~reset_req;

  assign bus.a_readdata = bus.mem_readdata;
  assign bus.b_readdata = bus.mem_readdata;

  assign bus.a_readdatavalid = tag.vld & (tag.own == GNT_A);
  assign bus.b_readdatavalid = tag.vld & (tag.own == GNT_B);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag        <= '{vld: 1'b0, own: GNT_B};
      last_grant <= GNT_B;
      burst_cnt  <= '0;
    end else begin
      tag <= '{vld: rd_issue, own: gnt_own};
      if (gnt_any) begin
        last_grant <= gnt_own;
`ifdef LEDTOGGLE_ARB_FIXED_PRI_EN
        burst_cnt  <= '0;
`else
        if (gnt_own != last_grant)
          burst_cnt <= BURST_W'(1);
        else if (burst_cnt != BURST_SAT)
          burst_cnt <= burst_cnt + BURST_W'(1);
`endif
      end
    end
  end

endmodule

// File: tb/tb_ledtoggle_onchip_mem_arbiter.sv
// Directed bench for ledtoggle_onchip_mem_arbiter with a RAM model.
// Build with LEDTOGGLE_ARB_FIXED_PRI_EN to run the fixed-priority case.
module tb_ledtoggle_onchip_mem_arbiter;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;

  logic clk;
  logic reset_n;
  logic reset_req;
  int   vectors;
  int   errors;

  ledtoggle_onchip_mem_arbiter_if #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) bus ();

  ledtoggle_onchip_mem_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MAX_BURST (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .reset_req (reset_req),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

  always @(posedge clk) begin
    if (bus.mem_clken && bus.mem_chipselect) begin
      if (bus.mem_write) begin
        for (int k = 0; k < DATA_W/8; k++)
          if (bus.mem_byteenable[k])
            ram[bus.mem_address][k*8 +: 8] <=
              bus.mem_writedata[k*8 +: 8];
      end
      bus.mem_readdata <= ram[bus.mem_address];
    end
  end

  function automatic logic [DATA_W-1:0] init_val(input int a);
    return 32'hA500_0000 | DATA_W'(a);
  endfunction

  task automatic idle();
    bus.a_read = 0; bus.a_write = 0;
    bus.b_read = 0; bus.b_write = 0;
    bus.a_address = '0; bus.b_address = '0;
    bus.a_byteenable = 4'hF; bus.b_byteenable = 4'hF;
    bus.a_writedata = '0; bus.b_writedata = '0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    idle();
    reset_n = 0;
    @(posedge clk); #1;
    reset_n = 1;
  endtask

  task automatic test_reset();
    reset_n = 0; reset_req = 0;
    idle();
    bus.a_read = 1; bus.b_write = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({bus.a_waitrequest, bus.b_waitrequest} !== 2'b11) begin
      errors++;
      $display("FAIL rst_wait got %b%b want 11",
               bus.a_waitrequest, bus.b_waitrequest);
    end
    vectors++;
    if ({bus.a_readdatavalid, bus.b_readdatavalid,
         bus.mem_chipselect, bus.mem_write} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_outs got rdv=%b%b cs=%b wr=%b want 0000",
               bus.a_readdatavalid, bus.b_readdatavalid,
               bus.mem_chipselect, bus.mem_write);
    end
    @(posedge clk); #1;
    idle();
    reset_n = 1;
  endtask

  task automatic test_write();
    @(posedge clk); #1;
    bus.a_write = 1; bus.a_address = 13'h0005;
    bus.a_writedata = 32'hDEAD_BEEF; bus.a_byteenable = 4'hF;
    @(negedge clk);
    vectors++;
    if ({bus.a_waitrequest, bus.b_waitrequest} !== 2'b01) begin
      errors++;
      $display("FAIL wr_wait got %b%b want 01",
               bus.a_waitrequest, bus.b_waitrequest);
    end
    vectors++;
    if ({bus.mem_chipselect, bus.mem_write, bus.mem_clken} !== 3'b111
        || bus.mem_address !== 13'h0005
        || bus.mem_writedata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL wr_mem got cs/wr/ck=%b%b%b a=%h d=%h want 111 0005 deadbeef",
               bus.mem_chipselect, bus.mem_write, bus.mem_clken,
               bus.mem_address, bus.mem_writedata);
    end
  endtask

  task automatic test_read();
    @(posedge clk); #1;
    bus.a_write = 0; bus.a_read = 1; bus.a_address = 13'h0005;
    @(negedge clk);
    vectors++;
    if (bus.a_waitrequest !== 1'b0 || bus.mem_write !== 1'b0
        || bus.a_readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL rd_issue got wait=%b wr=%b rdv=%b want 000",
               bus.a_waitrequest, bus.mem_write, bus.a_readdatavalid);
    end
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    vectors++;
    if (bus.a_readdatavalid !== 1'b1 || bus.b_readdatavalid !== 1'b0
        || bus.a_readdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rd_return got rdv=%b%b d=%h want 10 deadbeef",
               bus.a_readdatavalid, bus.b_readdatavalid, bus.a_readdata);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (bus.a_readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL rd_once got rdv=%b want 0", bus.a_readdatavalid);
    end
  endtask

  task automatic test_write_wins();
    @(posedge clk); #1;
    bus.b_read = 1; bus.b_write = 1; bus.b_address = 13'h0007;
    bus.b_writedata = 32'h1234_5678; bus.b_byteenable = 4'b0011;
    @(negedge clk);
    vectors++;
    if ({bus.a_waitrequest, bus.b_waitrequest, bus.mem_write} !== 3'b101
        || bus.mem_byteenable !== 4'b0011
        || bus.mem_address !== 13'h0007) begin
      errors++;
      $display("FAIL ww_grant got w=%b%b wr=%b be=%b a=%h want 101 0011 0007",
               bus.a_waitrequest, bus.b_waitrequest, bus.mem_write,
               bus.mem_byteenable, bus.mem_address);
    end
    @(posedge clk); #1;
    idle();
    bus.b_read = 1; bus.b_address = 13'h0007;
    @(negedge clk);
    vectors++;
    if (bus.b_readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL ww_nordv got rdv=%b want 0", bus.b_readdatavalid);
    end
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    vectors++;
    if (bus.b_readdatavalid !== 1'b1 || bus.b_readdata !== 32'hA500_5678) begin
      errors++;
      $display("FAIL ww_bytes got rdv=%b d=%h want 1 a5005678",
               bus.b_readdatavalid, bus.b_readdata);
    end
  endtask

  task automatic test_round_robin();
    logic        prev_b;
    int          prev_addr;
    logic        exp_b;
    pulse_reset();
    prev_b = 0; prev_addr = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      bus.a_read = 1; bus.a_address = ADDR_W'(13'h100 + i);
      bus.b_read = 1; bus.b_address = ADDR_W'(13'h200 + i);
      @(negedge clk);
      exp_b = ((i / 4) % 2) == 1;
      vectors++;
      if ({bus.a_waitrequest, bus.b_waitrequest} !== {exp_b, !exp_b}) begin
        errors++;
        $display("FAIL rr_grant[%0d] got %b%b want %b%b", i,
                 bus.a_waitrequest, bus.b_waitrequest, exp_b, !exp_b);
      end
      if (i > 0) begin
        vectors++;
        if ({bus.a_readdatavalid, bus.b_readdatavalid} !== {!prev_b, prev_b}
            || bus.a_readdata !== init_val(prev_addr)) begin
          errors++;
          $display("FAIL rr_route[%0d] got rdv=%b%b d=%h want %b%b %h", i,
                   bus.a_readdatavalid, bus.b_readdatavalid, bus.a_readdata,
                   !prev_b, prev_b, init_val(prev_addr));
        end
      end
      prev_b = exp_b;
      prev_addr = exp_b ? 'h200 + i : 'h100 + i;
    end
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    vectors++;
    if ({bus.a_readdatavalid, bus.b_readdatavalid} !== {!prev_b, prev_b}
        || bus.b_readdata !== init_val(prev_addr)) begin
      errors++;
      $display("FAIL rr_last got rdv=%b%b d=%h want %b%b %h",
               bus.a_readdatavalid, bus.b_readdatavalid, bus.b_readdata,
               !prev_b, prev_b, init_val(prev_addr));
    end
  endtask

  task automatic test_fixed_priority();
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      bus.a_read = 1; bus.a_address = ADDR_W'(13'h100 + i);
      bus.b_read = 1; bus.b_address = ADDR_W'(13'h200 + i);
      @(negedge clk);
      vectors++;
      if ({bus.a_waitrequest, bus.b_waitrequest} !== 2'b01) begin
        errors++;
        $display("FAIL fp_grant[%0d] got %b%b want 01", i,
                 bus.a_waitrequest, bus.b_waitrequest);
      end
    end
    @(posedge clk); #1;
    bus.a_read = 0;
    @(negedge clk);
    vectors++;
    if ({bus.a_waitrequest, bus.b_waitrequest} !== 2'b10) begin
      errors++;
      $display("FAIL fp_b_alone got %b%b want 10",
               bus.a_waitrequest, bus.b_waitrequest);
    end
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_reset_req();
    @(posedge clk); #1;
    idle();
    bus.a_read = 1; bus.a_address = 13'h0300;
    @(negedge clk);
    vectors++;
    if (bus.a_waitrequest !== 1'b0) begin
      errors++;
      $display("FAIL mr_pre got wait=%b want 0", bus.a_waitrequest);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      reset_req = 1; bus.a_address = 13'h0301;
      @(negedge clk);
      vectors++;
      if ({bus.a_waitrequest, bus.b_waitrequest,
           bus.mem_clken, bus.mem_chipselect} !== 4'b1100) begin
        errors++;
        $display("FAIL mr_stall[%0d] got w=%b%b ck=%b cs=%b want 1100", i,
                 bus.a_waitrequest, bus.b_waitrequest,
                 bus.mem_clken, bus.mem_chipselect);
      end
      vectors++;
      if (bus.a_readdatavalid !== (i == 0)
          || (i == 0 && bus.a_readdata !== init_val('h300))) begin
        errors++;
        $display("FAIL mr_rdv[%0d] got rdv=%b d=%h want %b %h", i,
                 bus.a_readdatavalid, bus.a_readdata, i == 0,
                 init_val('h300));
      end
    end
    @(posedge clk); #1;
    reset_req = 0;
    @(negedge clk);
    vectors++;
    if (bus.a_waitrequest !== 1'b0 || bus.mem_clken !== 1'b1) begin
      errors++;
      $display("FAIL mr_resume got wait=%b ck=%b want 01",
               bus.a_waitrequest, bus.mem_clken);
    end
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    vectors++;
    if (bus.a_readdatavalid !== 1'b1 || bus.a_readdata !== init_val('h301)) begin
      errors++;
      $display("FAIL mr_after got rdv=%b d=%h want 1 %h",
               bus.a_readdatavalid, bus.a_readdata, init_val('h301));
    end
  endtask

  task automatic test_reset_mid_read();
    @(posedge clk); #1;
    idle();
    bus.b_read = 1; bus.b_address = 13'h0400;
    @(negedge clk);
    vectors++;
    if (bus.b_waitrequest !== 1'b0) begin
      errors++;
      $display("FAIL rm_grant got wait=%b want 0", bus.b_waitrequest);
    end
    @(posedge clk); #1;
    bus.b_read = 0;
    reset_n = 0;
    @(negedge clk);
    vectors++;
    if (bus.b_readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL rm_discard got rdv=%b want 0", bus.b_readdatavalid);
    end
    @(posedge clk); #1;
    reset_n = 1;
    bus.a_read = 1; bus.b_read = 1;
    @(negedge clk);
    vectors++;
    if ({bus.a_waitrequest, bus.b_waitrequest} !== 2'b01) begin
      errors++;
      $display("FAIL rm_first got %b%b want 01",
               bus.a_waitrequest, bus.b_waitrequest);
    end
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    bus.mem_readdata = '0;
    for (int a = 0; a < (1 << ADDR_W); a++)
      ram[a] = init_val(a);
    test_reset();
    test_write();
    test_read();
    test_write_wins();
`ifdef LEDTOGGLE_ARB_FIXED_PRI_EN
    test_fixed_priority();
`else
    test_round_robin();
`endif
    test_reset_req();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
